// File: rtl/mul_sequencer.sv
// Radix-4 Booth sequential signed multiplier: one Booth digit per cycle into a
// carry-save pair, then a single carry-propagate add in RESOLVE.
// Optional early termination is enabled by defining MUL_EARLY_TERM_EN.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_multiplicand,
  input  logic [WIDTH-1:0] in_multiplier,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  localparam int PW   = 2 * WIDTH;
  localparam int NDIG = WIDTH / 2;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ITER    = 2'd1;
  localparam logic [1:0] S_RESOLVE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   qx_q, qx_d;       // multiplier with the Booth overlap bit appended at bit 0
  logic [KW-1:0]    k_q, k_d;
  logic [PW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    carry_q, carry_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             done_q, done_d;

  logic [2:0]       trip;
  logic             d_one, d_two, d_neg;
  logic [PW-1:0]    mext, pp_base, pp_shift, pp, maj;
  logic             last_digit, finish_iter;

  // Recode the current Booth digit and build its shifted partial product.
  // Negation inverts the already-shifted value so the low 2k bits become ones;
  // the +1 then lands at bit 0 of the carry vector, which is always free.
  always_comb begin
    trip     = 3'(qx_q >> {k_q, 1'b0});
    d_one    = trip[0] ^ trip[1];
    d_two    = (trip == 3'b011) || (trip == 3'b100);
    d_neg    = trip[2] && (trip != 3'b111);
    mext     = {{WIDTH{mcand_q[WIDTH-1]}}, mcand_q};
    pp_base  = '0;
    if (d_one) begin
      pp_base = mext;
    end else if (d_two) begin
      pp_base = mext << 1;
    end
    pp_shift = pp_base << {k_q, 1'b0};
    pp       = d_neg ? ~pp_shift : pp_shift;
    maj      = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
  end

  assign last_digit = (k_q == KW'(NDIG - 1));

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH:0] rest;

  // Stop once every bit above the digit just consumed (overlap bit included)
  // is a sign copy: all remaining Booth digits would be zero.
  always_comb begin
    rest        = $signed(qx_q) >>> (2 * int'(k_q) + 2);
    finish_iter = last_digit || (rest == '0) || (&rest);
  end
`else
  // Always walk every digit.
  always_comb begin
    finish_iter = last_digit;
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    qx_d    = qx_q;
    k_d     = k_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          mcand_d = in_multiplicand;
          qx_d    = {in_multiplier, 1'b0};
          k_d     = '0;
          sum_d   = '0;
          carry_d = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        sum_d   = sum_q ^ carry_q ^ pp;
        carry_d = (maj << 1) | PW'(d_neg);
        k_d     = k_q + 1'b1;
        if (finish_iter) begin
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        prod_d  = sum_q + carry_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything including the visible product.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      qx_q    <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      qx_q    <= qx_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign out_busy = (state_q == S_ITER) || (state_q == S_RESOLVE);
  assign out_done = done_q;
  assign out_hi   = prod_q[PW-1:WIDTH];
  assign out_lo   = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer (WIDTH=32): reference model of product and timing,
// per-cycle output comparison, directed literal cases and random traffic.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] m_in = '0;
  logic [31:0] q_in = '0;
  logic        out_busy, out_done;
  logic [31:0] out_hi, out_lo;

  int checks = 0;
  int errors = 0;

  mul_sequencer #(.WIDTH(32)) dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_start        (start),
    .in_multiplicand (m_in),
    .in_multiplier   (q_in),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_hi          (out_hi),
    .out_lo          (out_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Cycles from start edge to the cycle out_done is high.
  function automatic int lat_of(input logic [31:0] q);
`ifdef MUL_EARLY_TERM_EN
    longint v;
    longint lim;
    v = longint'($signed(q));
    for (int m = 1; m <= 16; m++) begin
      lim = longint'(1) << (2 * m - 1);
      if (v >= -lim && v < lim) return m + 1;   // Q fits in 2m signed bits
    end
    return 17;
`else
    return 17 + 0 * int'(q[0]);
`endif
  endfunction

  // ---------------- reference model ----------------
  int          cyc = 0;
  logic        m_active = 1'b0;
  int          m_done_at = 0;
  logic [63:0] m_pending = '0;
  logic [63:0] m_shown = '0;
  logic        exp_busy, exp_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_shown  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (start && (!m_active || cyc >= m_done_at)) begin
        m_active  <= 1'b1;
        m_done_at <= cyc + 1 + lat_of(q_in);
        m_pending <= 64'(longint'($signed(m_in)) * longint'($signed(q_in)));
      end
      if (m_active && (cyc + 1 == m_done_at)) m_shown <= m_pending;
    end
  end

  assign exp_busy = m_active && (cyc < m_done_at);
  assign exp_done = m_active && (cyc == m_done_at);

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", 64'(out_busy), 64'(exp_busy));
    chk("done", 64'(out_done), 64'(exp_done));
    chk("hi",   64'(out_hi),   64'(m_shown[63:32]));
    chk("lo",   64'(out_lo),   64'(m_shown[31:0]));
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input string nm, input logic [31:0] m, input logic [31:0] q,
                        input logic [31:0] ehi, input logic [31:0] elo, input int elat);
    int   e;
    logic found;
    @(negedge clk); #1;
    m_in = m; q_in = q; start = 1'b1;
    e = cyc + 1;
    @(negedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_done) begin
        found = 1'b1;
        chk({nm, " latency"}, 64'(cyc - e), 64'(elat));
        chk({nm, " hi"}, 64'(out_hi), 64'(ehi));
        chk({nm, " lo"}, 64'(out_lo), 64'(elo));
      end
    end
    if (!found) chk({nm, " done seen"}, 64'(found), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0;
      4: return 32'($urandom_range(0, 255));
      5: return 32'h0 - 32'($urandom_range(0, 255));
      default: return $urandom();
    endcase
  endfunction

`ifdef MUL_EARLY_TERM_EN
  localparam int L6 = 3, L5 = 3, L3 = 3, L0 = 2, LM1 = 2, NB2B = 10;
`else
  localparam int L6 = 17, L5 = 17, L3 = 17, L0 = 17, LM1 = 17, NB2B = 2;
`endif

  initial begin
    int   n;
    logic [31:0] cap_hi, cap_lo;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(out_busy), 64'd0);
    chk("reset done", 64'(out_done), 64'd0);
    chk("reset hi",   64'(out_hi),   64'd0);
    chk("reset lo",   64'(out_lo),   64'd0);
    #1 rst = 1'b0;

    run_op("7x6",       32'd7,         32'd6,         32'h0,         32'h2A,        L6);
    run_op("min x min", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         17);
    run_op("-3x5",      32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, L5);
    run_op("12345x0",   32'd12345,     32'd0,         32'h0,         32'h0,         L0);
    run_op("12345x3",   32'd12345,     32'd3,         32'h0,         32'd37035,     L3);
    run_op("-1x-1",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         LM1);

    // Start pulses while busy must be ignored.
    @(negedge clk); #1;
    m_in = 32'd100; q_in = 32'h7FFF_FFFF; start = 1'b1;
    n = 0; cap_hi = '0; cap_lo = '0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (out_done) begin
        n++; cap_hi = out_hi; cap_lo = out_lo;
      end
      #1;
      start = (c == 5) || (c == 9);
      if (start) begin
        m_in = 32'd999; q_in = 32'd999;
      end
    end
    chk("ignore done count", 64'(n), 64'd1);
    chk("ignore hi", 64'(cap_hi), 64'h31);
    chk("ignore lo", 64'(cap_lo), 64'hFFFF_FF9C);

    // Reset in the middle of ITER abandons the operation.
    @(negedge clk); #1;
    m_in = 32'h1234; q_in = 32'h4000_0001; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre-reset busy", 64'(out_busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid reset busy", 64'(out_busy), 64'd0);
    chk("mid reset done", 64'(out_done), 64'd0);
    chk("mid reset hi",   64'(out_hi),   64'd0);
    chk("mid reset lo",   64'(out_lo),   64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    run_op("2x3 after reset", 32'd2, 32'd3, 32'h0, 32'h6, L3);

    // Back-to-back with start held high.
    @(negedge clk); #1;
    m_in = 32'hFFFF_FFFD; q_in = 32'd5; start = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_done) n++;
    end
    #1 start = 1'b0;
    chk("b2b done count", 64'(n), 64'(NB2B));
    for (int i = 0; i < 40 && out_busy; i++) @(negedge clk);

    // Random traffic, including starts while busy and occasional resets.
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 3) != 0);
      m_in  = pick();
      q_in  = pick();
      rst   = ($urandom_range(0, 2999) == 0);
    end
    @(negedge clk); #1;
    start = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
